// File: rtl/clk_seq_pkg.sv
// Shared types and defaults for the clock phase sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package clk_seq_pkg;

   // Processor-cycle phases; encoding 2'd3 is unused and decodes to HALT.
   typedef enum logic [1:0] {
      ST_HALT = 2'd0,
      ST_MEM  = 2'd1,
      ST_CORE = 2'd2
   } state_t;

   localparam int DEF_CNT_W    = 32;
   localparam int DEF_WAIT_MAX = 15;
   localparam int DEF_WAIT_W   = 4;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive busy cycles while the sequencer sits in its MEM phase.
// Latency: expired is combinational from mem_busy and the registered count.
// Backpressure: mem_busy advances the count; expired flags the final tolerated wait.
module mem_wait_timer
   import clk_seq_pkg::*;
#(
   parameter int WAIT_MAX = DEF_WAIT_MAX,
   parameter int WAIT_W   = DEF_WAIT_W
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic in_mem,
   input  logic mem_busy,
   output logic expired
);

   localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(WAIT_MAX);

   logic [WAIT_W-1:0] wait_cnt;

   // Restart on every MEM entry, then count busy cycles up to the limit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wait_cnt <= '0;
      end else if (clear) begin
         wait_cnt <= '0;
      end else if (in_mem && mem_busy && (wait_cnt != WAIT_LIMIT)) begin
         wait_cnt <= wait_cnt + WAIT_W'(1);
      end
   end

   // Memory still busy after the last tolerated wait cycle.
   always_comb begin
      expired = mem_busy && (wait_cnt == WAIT_LIMIT);
   end

endmodule

// File: rtl/clock_phase_sequencer.sv
// Splits each processor cycle into MEM and CORE enable phases on one clock; run/halt/step control.
// Latency: first MEM enable 1 cycle after run (or step) is sampled in HALT; free-run period 2.
// Backpressure: mem_busy stretches MEM up to WAIT_MAX cycles, then a sticky timeout halts until reset.
module clock_phase_sequencer
   import clk_seq_pkg::*;
#(
   parameter int CNT_W    = DEF_CNT_W,
   parameter int WAIT_MAX = DEF_WAIT_MAX,
   parameter int WAIT_W   = DEF_WAIT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             run,
   input  logic             step,
   input  logic             mem_busy,
   output logic             imem_en,
   output logic             dmem_en,
   output logic             proc_en,
   output logic             regfile_en,
   output logic             halted,
   output logic             timeout,
   output logic [CNT_W-1:0] core_cycles
);

   state_t state;
   state_t next_state;
   logic   step_active;
   logic   set_step;
   logic   clr_step;
   logic   set_timeout;
   logic   core_done;
   logic   mem_entry;
   logic   in_mem;
   logic   expired;

   assign in_mem    = (state == ST_MEM);
   assign mem_entry = (next_state == ST_MEM) && (state != ST_MEM);

   mem_wait_timer #(
      .WAIT_MAX (WAIT_MAX),
      .WAIT_W   (WAIT_W)
   ) u_wait (
      .clk      (clk),
      .reset    (reset),
      .clear    (mem_entry),
      .in_mem   (in_mem),
      .mem_busy (mem_busy),
      .expired  (expired)
   );

   // Phase register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_HALT;
      end else begin
         state <= next_state;
      end
   end

   // Phase transitions; a started cycle always finishes unless memory times out.
   always_comb begin
      next_state  = ST_HALT;
      set_step    = 1'b0;
      clr_step    = 1'b0;
      set_timeout = 1'b0;
      core_done   = 1'b0;
      case (state)
         ST_HALT: begin
            if (!timeout) begin
               if (run) begin
                  next_state = ST_MEM;
               end else if (step) begin
                  next_state = ST_MEM;
                  set_step   = 1'b1;
               end
            end
         end
         ST_MEM: begin
            if (!mem_busy) begin
               next_state = ST_CORE;
            end else if (expired) begin
               next_state  = ST_HALT;
               set_timeout = 1'b1;
               clr_step    = 1'b1;
            end else begin
               next_state = ST_MEM;
            end
         end
         ST_CORE: begin
            core_done = 1'b1;
            if (step_active) begin
               clr_step = 1'b1;
            end else if (run) begin
               next_state = ST_MEM;
            end
         end
         default: next_state = ST_HALT;
      endcase
   end

   // Single-step marker, sticky timeout and retired-cycle counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         step_active <= 1'b0;
         timeout     <= 1'b0;
         core_cycles <= '0;
      end else begin
         if (set_step) begin
            step_active <= 1'b1;
         end else if (clr_step) begin
            step_active <= 1'b0;
         end
         if (set_timeout) begin
            timeout <= 1'b1;
         end
         if (core_done) begin
            core_cycles <= core_cycles + CNT_W'(1);
         end
      end
   end

   // Moore decode of the phase register into unit enables.
   always_comb begin
      imem_en    = 1'b0;
      dmem_en    = 1'b0;
      proc_en    = 1'b0;
      regfile_en = 1'b0;
      halted     = 1'b0;
      case (state)
         ST_MEM: begin
            imem_en = 1'b1;
            dmem_en = 1'b1;
         end
         ST_CORE: begin
            proc_en    = 1'b1;
            regfile_en = 1'b1;
         end
         default: halted = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_clock_phase_sequencer.sv
// Self-checking bench: directed scenarios plus randomized run/step/busy/reset traffic.
// Latency: outputs compared every falling edge against a cycle-level reference model.
// Backpressure: mem_busy bursts straddle the timeout limit from both sides.
module tb_clock_phase_sequencer;

   localparam int CNT_W    = 4;
   localparam int WAIT_MAX = 15;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             run = 1'b0;
   logic             step = 1'b0;
   logic             mem_busy = 1'b0;
   logic             imem_en;
   logic             dmem_en;
   logic             proc_en;
   logic             regfile_en;
   logic             halted;
   logic             timeout;
   logic [CNT_W-1:0] core_cycles;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   clock_phase_sequencer #(
      .CNT_W    (CNT_W),
      .WAIT_MAX (WAIT_MAX),
      .WAIT_W   (4)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .run         (run),
      .step        (step),
      .mem_busy    (mem_busy),
      .imem_en     (imem_en),
      .dmem_en     (dmem_en),
      .proc_en     (proc_en),
      .regfile_en  (regfile_en),
      .halted      (halted),
      .timeout     (timeout),
      .core_cycles (core_cycles)
   );

   // Reference model: where the processor cycle stands, how long memory has stalled,
   // whether this cycle was a single step, whether the machine is dead, cycles retired.
   int m_phase  = 0;   // 0 idle, 1 memory access, 2 core update
   int m_waited = 0;
   bit m_single = 1'b0;
   bit m_dead   = 1'b0;
   int m_count  = 0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_phase  = 0;
         m_waited = 0;
         m_single = 1'b0;
         m_dead   = 1'b0;
         m_count  = 0;
      end else begin
         case (m_phase)
            0: begin
               if (!m_dead && (run || step)) begin
                  m_single = !run;
                  m_phase  = 1;
                  m_waited = 0;
               end
            end
            1: begin
               if (!mem_busy) begin
                  m_phase = 2;
               end else if (m_waited == WAIT_MAX) begin
                  m_dead   = 1'b1;
                  m_single = 1'b0;
                  m_phase  = 0;
               end else begin
                  m_waited = m_waited + 1;
               end
            end
            2: begin
               m_count = (m_count + 1) % (1 << CNT_W);
               if (!m_single && run) begin
                  m_phase  = 1;
                  m_waited = 0;
               end else begin
                  m_phase = 0;
               end
               m_single = 1'b0;
            end
            default: m_phase = 0;
         endcase
      end
   end

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      logic [5+CNT_W:0] act;
      logic [5+CNT_W:0] exp;
      act = {imem_en, dmem_en, proc_en, regfile_en, halted, timeout, core_cycles};
      exp = {m_phase == 1, m_phase == 1, m_phase == 2, m_phase == 2, m_phase == 0,
             m_dead, CNT_W'(m_count)};
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL cycle_compare t=%0t: got %b expected %b", $time, act, exp);
      end
      checks++;
      if ((imem_en || dmem_en) && (proc_en || regfile_en)) begin
         errors++;
         $display("FAIL enable_overlap t=%0t: got imem=%b dmem=%b proc=%b reg=%b expected no overlap",
                  $time, imem_en, dmem_en, proc_en, regfile_en);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   initial begin
      int burst;
      burst = 0;
      #1 reset = 1'b1;
      repeat (2) @(posedge clk);
      #2;
      reset = 1'b0;
      chk("rst_halted", halted, 1);
      chk("rst_cycles", core_cycles, 0);
      chk("rst_imem", imem_en, 0);
      chk("rst_proc", proc_en, 0);
      chk("rst_timeout", timeout, 0);

      // Free-run, no stalls.
      run = 1'b1;
      tick(1);
      chk("t1_first_imem", imem_en, 1);
      chk("t1_first_dmem", dmem_en, 1);
      tick(1);
      chk("t1_core", proc_en, 1);
      tick(19);
      chk("t1_cycles", core_cycles, 10);
      chk("t1_mem", imem_en, 1);

      // Three busy cycles stretch MEM to four cycles.
      mem_busy = 1'b1;
      tick(3);
      chk("t2_stretch", imem_en, 1);
      mem_busy = 1'b0;
      tick(1);
      chk("t2_core", proc_en, 1);
      tick(1);
      chk("t2_cycles", core_cycles, 11);
      chk("t2_timeout", timeout, 0);

      // Busy held: sixteen MEM cycles, then timeout.
      mem_busy = 1'b1;
      tick(15);
      chk("t3_last_wait", imem_en, 1);
      chk("t3_no_timeout_yet", timeout, 0);
      tick(1);
      chk("t3_timeout", timeout, 1);
      chk("t3_halted", halted, 1);
      chk("t3_cycles", core_cycles, 11);
      step = 1'b1;
      tick(1);
      step = 1'b0;
      tick(3);
      chk("t3_stuck_halted", halted, 1);
      chk("t3_stuck_imem", imem_en, 0);
      reset = 1'b1;
      #1;
      chk("t3_reset_timeout", timeout, 0);
      chk("t3_reset_halted", halted, 1);
      run = 1'b0;
      mem_busy = 1'b0;
      tick(1);
      reset = 1'b0;

      // Single step from HALT.
      step = 1'b1;
      tick(1);
      step = 1'b0;
      chk("t4_step_mem", imem_en, 1);
      tick(1);
      chk("t4_step_core", proc_en, 1);
      tick(1);
      chk("t4_step_halt", halted, 1);
      chk("t4_step_cycles", core_cycles, 1);
      tick(2);
      chk("t4_stays_halted", halted, 1);
      chk("t4_stays_cycles", core_cycles, 1);
      run = 1'b1;
      tick(1);
      chk("t4_run_mem", imem_en, 1);
      step = 1'b1;
      tick(1);
      step = 1'b0;
      chk("t4_step_ignored_core", proc_en, 1);
      tick(3);
      chk("t4_freerun_cycles", core_cycles, 3);
      chk("t4_freerun_mem", imem_en, 1);

      // Run dropped during MEM: cycle completes, then halt.
      run = 1'b0;
      tick(1);
      chk("t5_core_completes", proc_en, 1);
      tick(1);
      chk("t5_halted", halted, 1);
      chk("t5_cycles", core_cycles, 4);
      run = 1'b1;
      step = 1'b1;
      tick(1);
      step = 1'b0;
      chk("t5_both_mem", imem_en, 1);
      tick(2);
      chk("t5_no_halt", imem_en, 1);
      chk("t5_cycles2", core_cycles, 5);

      // Asynchronous reset during CORE, then counter wrap.
      tick(1);
      chk("t6_in_core", proc_en, 1);
      reset = 1'b1;
      #1;
      chk("t6_async_proc", proc_en, 0);
      chk("t6_async_regfile", regfile_en, 0);
      chk("t6_async_halted", halted, 1);
      chk("t6_async_cycles", core_cycles, 0);
      tick(1);
      reset = 1'b0;
      tick(31);
      chk("t6_before_wrap", core_cycles, 15);
      tick(2);
      chk("t6_wrap", core_cycles, 0);
      chk("t6_wrap_mem", imem_en, 1);

      // Randomized traffic.
      for (int i = 0; i < 4000; i++) begin
         run  = ($urandom_range(0, 9) < 7);
         step = ($urandom_range(0, 4) == 0);
         if (burst > 0) begin
            mem_busy = 1'b1;
            burst--;
         end else if ($urandom_range(0, 39) == 0) begin
            burst = $urandom_range(13, 17);
            mem_busy = 1'b1;
         end else begin
            mem_busy = ($urandom_range(0, 3) == 0);
         end
         reset = ($urandom_range(0, 119) == 0);
         tick(1);
      end
      reset = 1'b0;
      run = 1'b0;
      step = 1'b0;
      mem_busy = 1'b0;
      tick(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
